// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: merges ALU/load writeback with buffered mul/div results.
// Optional decode bypass hit outputs are enabled with `define RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        Resetn,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        RegWr,
    output logic [4:0]  Rw,
    output logic [31:0] busW,
    output logic [31:0] md_pending,
    output logic        wb_stall,
    input  logic [4:0]  Ra,
    input  logic [4:0]  Rb,
    output logic        fwd_a_hit,
    output logic        fwd_b_hit
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [3:0]    LIMIT    = 4'(STARVE_LIMIT);

    if (!(FIFO_DEPTH == 2 || FIFO_DEPTH == 4 || FIFO_DEPTH == 8)) begin : g_bad_depth
        $error("rf_wb_arbiter: FIFO_DEPTH must be 2, 4 or 8");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("rf_wb_arbiter: STARVE_LIMIT must be 1..15");
    end

    logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          regwr_q, regwr_d;
    logic [4:0]    rw_q, rw_d;
    logic [31:0]   busw_q, busw_d;
    logic [3:0]    starve_q, starve_d;
    logic          stall_q, stall_d;

    logic          fifo_empty, fifo_full, md_ready_int;
    logic          md_hs, md_keep, alu_win;
    logic          push, pop;

    always_comb begin
        fifo_empty   = (count_q == '0);
        fifo_full    = (count_q == FULL_CNT);
        // Readiness is a function of registered occupancy only.
        md_ready_int = !fifo_full && Resetn;
        md_hs        = md_valid && md_ready_int;
        md_keep      = md_hs && (md_rd != 5'd0);
        alu_win      = alu_valid && (alu_rd != 5'd0);
    end

    always_comb begin
        regwr_d = 1'b0;
        rw_d    = rw_q;
        busw_d  = busw_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (alu_win) begin
            regwr_d = 1'b1;
            rw_d    = alu_rd;
            busw_d  = alu_data;
            push    = md_keep;
        end else if (!fifo_empty) begin
            regwr_d = 1'b1;
            rw_d    = fifo_rd_q[rd_ptr_q];
            busw_d  = fifo_data_q[rd_ptr_q];
            pop     = 1'b1;
            push    = md_keep;
        end else if (md_keep) begin
            regwr_d = 1'b1;
            rw_d    = md_rd;
            busw_d  = md_data;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Non-empty without a pop can only mean the ALU took the slot.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = 4'd0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 4'd1;
        end
        stall_d = pop ? 1'b0 : (stall_q || (starve_q == LIMIT));
    end

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            regwr_q  <= 1'b0;
            rw_q     <= 5'd0;
            busw_q   <= 32'd0;
            starve_q <= 4'd0;
            stall_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            regwr_q  <= regwr_d;
            rw_q     <= rw_d;
            busw_q   <= busw_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    // Entry storage needs no reset; validity comes from the pointers and count.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= md_rd;
            fifo_data_q[wr_ptr_q] <= md_data;
        end
    end

    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        md_pending = 32'd0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                md_pending[fifo_rd_q[idx]] = 1'b1;
            end
        end
    end

    assign md_ready = md_ready_int;
    assign RegWr    = regwr_q;
    assign Rw       = rw_q;
    assign busW     = busw_q;
    assign wb_stall = stall_q;

`ifdef RF_WB_BYPASS_EN
    assign fwd_a_hit = regwr_q && (rw_q == Ra) && (Ra != 5'd0);
    assign fwd_b_hit = regwr_q && (rw_q == Rb) && (Rb != 5'd0);
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{Ra, Rb};
    assign fwd_a_hit      = 1'b0;
    assign fwd_b_hit      = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_rf_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        Resetn = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        md_valid = 1'b0;
    logic        md_ready;
    logic [4:0]  md_rd = '0;
    logic [31:0] md_data = '0;
    logic        RegWr;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic [31:0] md_pending;
    logic        wb_stall;
    logic [4:0]  Ra = '0;
    logic [4:0]  Rb = '0;
    logic        fwd_a_hit, fwd_b_hit;

    always #5 CLK = ~CLK;

    rf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .Resetn(Resetn),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
        .RegWr(RegWr), .Rw(Rw), .busW(busW), .md_pending(md_pending),
        .wb_stall(wb_stall), .Ra(Ra), .Rb(Rb),
        .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_regwr;
    logic [4:0]  m_rw;
    logic [31:0] m_busw;
    int          m_lost;
    logic        m_stall;
    int          errors = 0;
    int          checks = 0;
    bit          chk_en = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] m;
        m = 32'd0;
        foreach (q[i]) m = m | (32'd1 << q[i].rd);
        return m;
    endfunction

    function automatic logic model_fwd(logic [4:0] r);
`ifdef RF_WB_BYPASS_EN
        return m_regwr && (m_rw == r) && (r != 5'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_regwr = 1'b0;
        m_rw    = 5'd0;
        m_busw  = 32'd0;
        m_lost  = 0;
        m_stall = 1'b0;
    endtask

    // One clock edge of the specified arbitration, from the inputs presented this cycle.
    task automatic model_update();
        bit   was_empty, popped, accepted;
        int   old_lost;
        ent_t head;
        if (!Resetn) return;
        was_empty = (q.size() == 0);
        old_lost  = m_lost;
        accepted  = md_valid && (q.size() < DEPTH) && (md_rd != 5'd0);
        popped    = 0;
        if (alu_valid && alu_rd != 5'd0) begin
            m_regwr = 1'b1; m_rw = alu_rd; m_busw = alu_data;
            if (accepted) q.push_back('{rd: md_rd, data: md_data});
        end else if (!was_empty) begin
            head = q.pop_front();
            popped = 1;
            m_regwr = 1'b1; m_rw = head.rd; m_busw = head.data;
            if (accepted) q.push_back('{rd: md_rd, data: md_data});
        end else if (accepted) begin
            m_regwr = 1'b1; m_rw = md_rd; m_busw = md_data;
        end else begin
            m_regwr = 1'b0;
        end
        m_stall = popped ? 1'b0 : (m_stall || old_lost == LIMIT);
        m_lost  = (was_empty || popped) ? 0 : ((old_lost + 1 > LIMIT) ? LIMIT : old_lost + 1);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("md_ready", md_ready, Resetn && (q.size() < DEPTH));
            chk("RegWr", RegWr, m_regwr);
            chk("Rw", Rw, m_rw);
            chk("busW", busW, m_busw);
            chk("md_pending", md_pending, model_pending());
            chk("wb_stall", wb_stall, m_stall);
            chk("fwd_a_hit", fwd_a_hit, model_fwd(Ra));
            chk("fwd_b_hit", fwd_b_hit, model_fwd(Rb));
        end
    end

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        md_valid  = 1'b0;
    endtask

    initial begin
        int p_alu, p_md;
        bit honor;
        model_reset();
        chk_en = 1;
        #1;
        chk("rst RegWr", RegWr, 1'b0);
        chk("rst md_ready", md_ready, 1'b0);
        chk("rst md_pending", md_pending, 32'd0);
        chk("rst wb_stall", wb_stall, 1'b0);
        @(negedge CLK); #2; Resetn = 1'b1;
        tick();
        chk("post-rst md_ready", md_ready, 1'b1);

        // ALU only
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        tick();
        chk("alu RegWr", RegWr, 1'b1);
        chk("alu Rw", Rw, 5'd5);
        chk("alu busW", busW, 32'h1234);
        alu_rd = 0; alu_data = 32'hFFFF;
        tick();
        chk("alu r0 RegWr", RegWr, 1'b0);
        chk("alu r0 Rw hold", Rw, 5'd5);
        chk("alu r0 busW hold", busW, 32'h1234);

        // Collision
        alu_rd = 3; alu_data = 32'h33; md_valid = 1; md_rd = 7; md_data = 32'hAA;
        tick();
        chk("col Rw3", Rw, 5'd3);
        chk("col pending7", md_pending, 32'h80);
        idle();
        tick();
        chk("col RegWr", RegWr, 1'b1);
        chk("col Rw7", Rw, 5'd7);
        chk("col busW", busW, 32'hAA);
        chk("col pending clr", md_pending, 32'd0);
        tick();
        chk("col idle", RegWr, 1'b0);

        // Fill
        alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
        md_valid = 1; md_rd = 10; md_data = 32'hA0;
        tick();
        chk("fill ready1", md_ready, 1'b1);
        md_rd = 11; md_data = 32'hA1;
        tick();
        chk("fill ready0", md_ready, 1'b0);
        md_rd = 12; md_data = 32'hA2;
        tick();
        chk("fill still0", md_ready, 1'b0);
        chk("fill pending", md_pending, 32'h0000_0C00);
        idle();
        tick();
        chk("drain1 Rw", Rw, 5'd10);
        chk("drain1 busW", busW, 32'hA0);
        chk("drain1 ready", md_ready, 1'b1);
        tick();
        chk("drain2 Rw", Rw, 5'd11);
        chk("drain2 busW", busW, 32'hA1);
        tick();
        chk("drain done", RegWr, 1'b0);

        // Starvation
        alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
        md_valid = 1; md_rd = 20; md_data = 32'hBB;
        tick();
        md_valid = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("starve stall", wb_stall, (k >= 5) ? 1'b1 : 1'b0);
        end
        alu_valid = 0;
        tick();
        chk("starve pop Rw", Rw, 5'd20);
        chk("starve pop busW", busW, 32'hBB);
        chk("starve stall clr", wb_stall, 1'b0);

        // Reset mid-fill
        alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
        md_valid = 1; md_rd = 21; md_data = 32'hC1;
        tick();
        md_rd = 22; md_data = 32'hC2;
        tick();
        chk("rmid pending", md_pending, 32'h0060_0000);
        Resetn = 1'b0;
        model_reset();
        #1;
        chk("rmid RegWr", RegWr, 1'b0);
        chk("rmid pending0", md_pending, 32'd0);
        chk("rmid stall", wb_stall, 1'b0);
        chk("rmid ready", md_ready, 1'b0);
        idle();
        @(negedge CLK); #2; Resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rmid no replay", RegWr, 1'b0);
        end

        // Bypass
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        tick();
        idle();
        Ra = 9; Rb = 0;
        #1;
`ifdef RF_WB_BYPASS_EN
        chk("byp a", fwd_a_hit, 1'b1);
`else
        chk("byp a", fwd_a_hit, 1'b0);
`endif
        chk("byp b", fwd_b_hit, 1'b0);

        // Randomized traffic
        for (int seg = 0; seg < 8; seg++) begin
            p_alu = $urandom_range(10, 95);
            p_md  = $urandom_range(10, 95);
            honor = 1'($urandom_range(0, 1));
            for (int c = 0; c < 400; c++) begin
                alu_valid = ($urandom_range(0, 99) < p_alu) && !(honor && m_stall);
                alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                alu_data  = $urandom;
                md_valid  = ($urandom_range(0, 99) < p_md);
                md_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                md_data   = $urandom;
                Ra        = ($urandom_range(0, 2) == 0) ? m_rw : 5'($urandom_range(0, 31));
                Rb        = ($urandom_range(0, 2) == 0) ? m_rw : 5'($urandom_range(0, 31));
                tick();
                if ($urandom_range(0, 499) == 0) begin
                    Resetn = 1'b0;
                    model_reset();
                    #2;
                    Resetn = 1'b1;
                end
            end
        end

        idle();
        tick();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-side front end for the 32x32 register file; the sole driver of its single write port (RegWr/Rw/busW).
Merges two writeback sources into that one port:
- the in-order ALU/load pipeline (fixed slot, no backpressure);
- the multicycle mul/div unit (valid/ready handshake).
Mul/div results that lose arbitration are buffered. The block exports a pending-write mask for the hazard unit and a starvation stall request for the pipeline.

Parameters:
FIFO_DEPTH, 2, mul/div result buffer entries; legal values 2, 4, 8.
STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose arbitration before wb_stall asserts; legal range 1..15.

Ports:
CLK  input  1  clock, all state updates on rising edge
Resetn  input  1  asynchronous active-low reset
alu_valid  input  1  ALU/load writeback slot carries a result this cycle
alu_rd  input  5  ALU destination register
alu_data  input  32  ALU result
md_valid  input  1  mul/div result offered
md_ready  output  1  mul/div result accepted when md_valid && md_ready
md_rd  input  5  mul/div destination register
md_data  input  32  mul/div result
RegWr  output  1  register file write enable (registered)
Rw  output  5  register file write address (registered)
busW  output  32  register file write data (registered)
md_pending  output  32  bit i = 1 while a buffered mul/div write to register i is in the FIFO
wb_stall  output  1  request that the pipeline present alu_valid=0 next cycle (registered)
Ra  input  5  decode read address 1, for bypass
Rb  input  5  decode read address 2, for bypass
fwd_a_hit  output  1  bypass busW for port A
fwd_b_hit  output  1  bypass busW for port B

Behaviour:
Reset (Resetn=0, asynchronous): RegWr=0, Rw=0, busW=0, FIFO empty, md_pending=0, wb_stall=0, starvation counter=0, md_ready=0. After release, md_ready=1.

Readiness:
- md_ready = !fifo_full && Resetn. It depends on registered state only, never on same-cycle inputs.
- A full FIFO that pops this cycle still shows md_ready=0 this cycle.

Per-cycle arbitration, in priority order, evaluated combinationally and registered into RegWr/Rw/busW:
1. alu_valid && alu_rd!=0 -> write ALU result. A mul/div handshake this cycle (md_rd!=0) pushes to the FIFO.
2. Else, FIFO non-empty -> write the FIFO head and pop. A same-cycle handshake pushes behind it.
3. Else, FIFO empty and handshake with md_rd!=0 -> write md directly, no FIFO entry. Latency 1 cycle.
4. Else -> RegWr=0. Rw/busW hold their previous value.

Register 0:
- Writes to register 0 are never issued.
- alu_valid with alu_rd=0 frees the slot for rules 2/3.
- An md handshake with md_rd=0 is accepted and discarded.

Latency: ALU result to RegWr is 1 cycle. Mul/div is 1 cycle when unbuffered, otherwise FIFO position + 1.

FIFO:
- Circular buffer, pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop is legal at any occupancy below full.
- Occupancy count is clog2(FIFO_DEPTH)+1 bits.

md_pending:
- OR of one-hot decodes of all valid FIFO entries.
- Updated on the same edge as push/pop; an entry popped this edge clears its bit on that edge.

Ordering: a buffered register must not be targeted by a new ALU write. The hazard unit enforces this using md_pending; this block does not check it.

Starvation:
- The counter increments each cycle the FIFO is non-empty and rule 1 wins.
- It resets to 0 on any pop or when the FIFO is empty, and saturates at STARVE_LIMIT.
- wb_stall is registered: it is 1 in the cycle after the counter equals STARVE_LIMIT and stays 1 until a pop occurs.
- If alu_valid arrives anyway while wb_stall=1, the ALU still wins and no result is lost.

Reset mid-operation discards all FIFO contents and any write not yet presented; nothing is replayed.

Optional Feature:
RF_WB_BYPASS_EN:
- Defined: fwd_a_hit = RegWr && Rw==Ra && Ra!=0; fwd_b_hit likewise for Rb. Decode muxes busW over the register file output when hit is set, covering the edge on which the file is written.
- Undefined: fwd_a_hit = fwd_b_hit = 0 constantly, and Ra/Rb are unused.

Test Plan:
- ALU only: alu_valid=1, rd=5, data=0x1234 -> next cycle RegWr=1, Rw=5, busW=0x1234. rd=0 -> RegWr=0.
- Collision: alu rd=3 and md rd=7 (data 0xAA) in the same cycle -> cycle+1 writes r3; cycle+2 writes r7=0xAA; md_pending[7]=1 for exactly 1 cycle.
- Fill: FIFO_DEPTH=2, alu_valid held with rd=1, three md offers -> md_ready drops after 2 accepted; entries drain in FIFO order once alu_valid=0.
- Starvation: STARVE_LIMIT=4, FIFO holds 1 entry, alu_valid held -> wb_stall=1 on the 5th cycle; alu_valid=0 -> pop, and wb_stall=0 on the following cycle.
- Reset mid-fill: 2 entries buffered, pulse Resetn low asynchronously -> RegWr=0, md_pending=0, wb_stall=0 immediately; no buffered writes appear afterwards.
- Bypass (macro defined): RegWr=1, Rw=9, Ra=9, Rb=0 -> fwd_a_hit=1, fwd_b_hit=0. Macro undefined -> both 0.
